prime_sim: RTL and testbench

- Hardware-threaded prime search engine, the DUT of the prime simulation top level.
- On a run (or start) request it finds every prime p with 2 <= p < LIMIT by trial division, using repeated subtraction (no divider).
- It exposes the result count and the last prime found, then raises the public field finish_flag, which the top level polls to end simulation.
- Uses the standard method handshake: *_req / *_busy for run, start, join and yield.

---
 rtl/prime_sim_pkg.sv | 36 +++
 rtl/prime_sim_mod_unit.sv | 67 ++++++
 rtl/prime_sim.sv | 191 +++++++++++++++++++
 tb/tb_prime_sim.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prime_sim_pkg.sv
// ---------------------------------------------------------------------------
// prime_sim_pkg
//   Shared definitions for the prime search engine:
//     - state_e           : controller states
//     - DEFAULT_WIDTH     : default datapath width of counters and outputs
//     - DEFAULT_LIMIT     : default exclusive upper bound of the search
//     - HS_* constants    : levels used on the *_busy method handshake outputs
//     - hs_busy()         : maps a controller state to the busy level
// ---------------------------------------------------------------------------
package prime_sim_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_LIMIT = 100;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_CAND = 3'd2,
        S_DCHK = 3'd3,
        S_MOD  = 3'd4,
        S_MCHK = 3'd5,
        S_REC  = 3'd6,
        S_DONE = 3'd7
    } state_e;

    // Method-handshake levels.
    localparam logic HS_IDLE       = 1'b0;
    localparam logic HS_BUSY       = 1'b1;
    localparam logic HS_YIELD_BUSY = 1'b0;  // yield() never blocks

    // A method is busy whenever the worker is anywhere but IDLE.
    function automatic logic hs_busy(input state_e s);
        return (s != S_IDLE) ? HS_BUSY : HS_IDLE;
    endfunction

endpackage

// File: rtl/prime_sim_mod_unit.sv
// ---------------------------------------------------------------------------
// prime_sim_mod_unit
//   Sequential remainder unit: computes n mod d by repeated subtraction,
//   one subtraction per clock, so no divider is needed.
//
//   Ports:
//     clk    in   system clock
//     reset  in   asynchronous active-low reset
//     start  in   load n and d and begin reducing (ignored unless pulsed)
//     n      in   dividend, sampled on the start edge
//     d      in   divisor, sampled on the start edge (must be nonzero)
//     done   out  high for the one cycle in which the remainder is final
//     zero   out  remainder == 0 (valid while done is high and afterwards
//                 until the next start)
// ---------------------------------------------------------------------------
module prime_sim_mod_unit
    import prime_sim_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] d,
    output logic             done,
    output logic             zero
);

    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] dv_q, dv_d;
    logic             busy_q, busy_d;

    always_comb begin
        r_d    = r_q;
        dv_d   = dv_q;
        busy_d = busy_q;
        if (start) begin
            r_d    = n;
            dv_d   = d;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (r_q >= dv_q) begin
                r_d = r_q - dv_q;
            end else begin
                // Remainder is final this cycle; stop until the next start.
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q    <= '0;
            dv_q   <= '0;
            busy_q <= 1'b0;
        end else begin
            r_q    <= r_d;
            dv_q   <= dv_d;
            busy_q <= busy_d;
        end
    end

    assign done = busy_q && (r_q < dv_q);
    assign zero = (r_q == '0);

endmodule

// File: rtl/prime_sim.sv
// ---------------------------------------------------------------------------
// prime_sim
//   Hardware-threaded prime search engine. A run (or start) request walks
//   every candidate 2 <= n < LIMIT, trial-dividing by d = 2, 3, ... while
//   d*d <= n. Primes bump the count and update the last-prime register.
//   When the sweep ends, finish_flag is raised for the top level to poll.
//
//   Parameters:
//     LIMIT  exclusive upper bound of the search (2..65536); WIDTH must be
//            wide enough to hold LIMIT
//     WIDTH  datapath width of counters and outputs
//
//   Ports:
//     clk                          in   system clock, rising edge
//     reset                        in   asynchronous active-low reset
//     field_finish_flag_output     out  finish_flag field value
//     field_finish_flag_input      in   external write data for finish_flag
//     field_finish_flag_input_we   in   external write enable for finish_flag
//     field_prime_count_output     out  primes found so far
//     field_last_prime_output      out  most recent prime (0 if none)
//     run_req / run_busy           method run(): request / busy
//     start_req / start_busy       thread start: same as run()
//     join_req / join_busy         join: busy while requested and running
//     yield_req / yield_busy       yield: no-op, never busy
// ---------------------------------------------------------------------------
module prime_sim
    import prime_sim_pkg::*;
#(
    parameter int LIMIT = DEFAULT_LIMIT,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    output logic             field_finish_flag_output,
    input  logic             field_finish_flag_input,
    input  logic             field_finish_flag_input_we,
    output logic [WIDTH-1:0] field_prime_count_output,
    output logic [WIDTH-1:0] field_last_prime_output,
    input  logic             run_req,
    output logic             run_busy,
    input  logic             start_req,
    output logic             start_busy,
    input  logic             join_req,
    output logic             join_busy,
    input  logic             yield_req,
    output logic             yield_busy
);

    localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             finish_q, finish_d;
    logic             busy_q, busy_d;

    logic             mod_start;
    logic             mod_done;
    logic             mod_zero;

    // Square in double width so d*d can never wrap and falsely look small.
    logic [2*WIDTH-1:0] div_sq;
    logic [2*WIDTH-1:0] n_ext;
    logic               div_sq_gt_n;

    assign div_sq      = {{WIDTH{1'b0}}, div_q} * {{WIDTH{1'b0}}, div_q};
    assign n_ext       = {{WIDTH{1'b0}}, n_q};
    assign div_sq_gt_n = (div_sq > n_ext);

    prime_sim_mod_unit #(
        .WIDTH (WIDTH)
    ) u_mod_unit (
        .clk   (clk),
        .reset (reset),
        .start (mod_start),
        .n     (n_q),
        .d     (div_q),
        .done  (mod_done),
        .zero  (mod_zero)
    );

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        div_d     = div_q;
        count_d   = count_q;
        last_d    = last_q;
        finish_d  = finish_q;
        mod_start = 1'b0;

        // External field write first so INIT/DONE below override it.
        if (field_finish_flag_input_we) begin
            finish_d = field_finish_flag_input;
        end

        case (state_q)
            S_IDLE: begin
                if (run_req || start_req) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                finish_d = 1'b0;
                count_d  = '0;
                last_d   = '0;
                n_d      = TWO;
                state_d  = S_CAND;
            end
            S_CAND: begin
                if (n_q >= LIMIT_W) begin
                    state_d = S_DONE;
                end else begin
                    div_d   = TWO;
                    state_d = S_DCHK;
                end
            end
            S_DCHK: begin
                if (div_sq_gt_n) begin
                    state_d = S_REC;
                end else begin
                    // Remainder unit loads n and d on this edge.
                    mod_start = 1'b1;
                    state_d   = S_MOD;
                end
            end
            S_MOD: begin
                if (mod_done) begin
                    state_d = S_MCHK;
                end
            end
            S_MCHK: begin
                if (mod_zero) begin
                    n_d     = n_q + ONE;
                    state_d = S_CAND;
                end else begin
                    div_d   = div_q + ONE;
                    state_d = S_DCHK;
                end
            end
            S_REC: begin
                count_d = count_q + ONE;
                last_d  = n_q;
                n_d     = n_q + ONE;
                state_d = S_CAND;
            end
            S_DONE: begin
                finish_d = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = hs_busy(state_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            div_q    <= '0;
            count_q  <= '0;
            last_q   <= '0;
            finish_q <= 1'b0;
            busy_q   <= HS_IDLE;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            div_q    <= div_d;
            count_q  <= count_d;
            last_q   <= last_d;
            finish_q <= finish_d;
            busy_q   <= busy_d;
        end
    end

    assign field_finish_flag_output = finish_q;
    assign field_prime_count_output = count_q;
    assign field_last_prime_output  = last_q;
    assign run_busy                 = busy_q;
    assign start_busy               = busy_q;
    // Only combinational output path: join reflects the live request.
    assign join_busy                = join_req & busy_q;
    assign yield_busy               = yield_req & HS_YIELD_BUSY;

endmodule

// File: tb/tb_prime_sim.sv
module tb_prime_sim;

    logic        clk;
    logic        reset;
    logic        ff_in;
    logic        ff_we;
    logic [2:0]  run_req;
    logic [2:0]  start_req;
    logic        join_req;
    logic        yield_req;

    logic [2:0]  ff_o;
    logic [2:0]  run_busy_o;
    logic [2:0]  start_busy_o;
    logic [2:0]  join_busy_o;
    logic [2:0]  yield_busy_o;
    logic [31:0] cnt_o  [3];
    logic [31:0] last_o [3];

    // Three engines with different search bounds share clock, reset and
    // the field/join/yield inputs; run/start requests are per engine.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 100 : ((g == 1) ? 30 : 2);
        prime_sim #(.LIMIT(L), .WIDTH(32)) u_dut (
            .clk                        (clk),
            .reset                      (reset),
            .field_finish_flag_output   (ff_o[g]),
            .field_finish_flag_input    (ff_in),
            .field_finish_flag_input_we (ff_we),
            .field_prime_count_output   (cnt_o[g]),
            .field_last_prime_output    (last_o[g]),
            .run_req                    (run_req[g]),
            .run_busy                   (run_busy_o[g]),
            .start_req                  (start_req[g]),
            .start_busy                 (start_busy_o[g]),
            .join_req                   (join_req),
            .join_busy                  (join_busy_o[g]),
            .yield_req                  (yield_req),
            .yield_busy                 (yield_busy_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        int cnt;
        int last;
        int cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_checks = 0;
    int n_fail   = 0;
    int lims     [3] = '{100, 30, 2};
    int ref_cnt  [3];
    int ref_last [3];
    int ref_cyc  [3];
    int maxd;

    // Reference: primality by plain modulo; busy length from the state
    // sequence (INIT, per-candidate CAND, per-divisor DCHK then either REC
    // or MOD for floor(n/d)+1 cycles plus MCHK, final CAND, DONE).
    function automatic void ref_run(input int lim, output int cnt, output int last, output int cyc);
        cnt  = 0;
        last = 0;
        cyc  = 1;
        for (int n = 2; n < lim; n++) begin
            int d;
            bit open;
            cyc++;
            d    = 2;
            open = 1'b1;
            while (open) begin
                cyc++;
                if (d * d > n) begin
                    cyc++;
                    cnt++;
                    last = n;
                    open = 1'b0;
                end else begin
                    cyc += n / d + 2;
                    if (n % d == 0) open = 1'b0;
                    else d++;
                end
            end
        end
        cyc += 2;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int qsize(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t pop_exp(input int i);
        exp_t e;
        e = '0;
        case (i)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        return e;
    endfunction

    task automatic push_exp(input int i);
        exp_t e;
        e.cnt  = ref_cnt[i];
        e.last = ref_last[i];
        e.cyc  = ref_cyc[i];
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Completion monitor: a falling run_busy (outside reset) is a finished
    // run; the oldest expectation for that engine is popped and compared.
    task automatic monitor();
        bit prev [3];
        int bcnt [3];
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            prev[i] = 1'b0;
            bcnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!reset) begin
                    prev[i] = 1'b0;
                    bcnt[i] = 0;
                end else if (run_busy_o[i]) begin
                    prev[i] = 1'b1;
                    bcnt[i]++;
                end else if (prev[i]) begin
                    prev[i] = 1'b0;
                    if (qsize(i) == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL dut%0d_unexpected_done: got completion expected none", i);
                    end else begin
                        e = pop_exp(i);
                        chk($sformatf("dut%0d_count", i), cnt_o[i], e.cnt);
                        chk($sformatf("dut%0d_last", i), last_o[i], e.last);
                        chk($sformatf("dut%0d_finish_flag", i), ff_o[i], 1);
                        chk($sformatf("dut%0d_busy_cycles", i), bcnt[i], e.cyc);
                    end
                    bcnt[i] = 0;
                end
            end
        end
    endtask

    initial begin
        reset     = 1'b0;
        ff_in     = 1'b0;
        ff_we     = 1'b0;
        run_req   = 3'b000;
        start_req = 3'b000;
        join_req  = 1'b1;
        yield_req = 1'b1;

        maxd = 0;
        for (int i = 0; i < 3; i++) begin
            ref_run(lims[i], ref_cnt[i], ref_last[i], ref_cyc[i]);
            if (ref_cyc[i] > maxd) maxd = ref_cyc[i];
        end

        fork
            monitor();
        join_none

        // Reset state
        cyc(5);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst%0d_ff", i), ff_o[i], 0);
            chk($sformatf("rst%0d_cnt", i), cnt_o[i], 0);
            chk($sformatf("rst%0d_last", i), last_o[i], 0);
            chk($sformatf("rst%0d_run_busy", i), run_busy_o[i], 0);
            chk($sformatf("rst%0d_start_busy", i), start_busy_o[i], 0);
            chk($sformatf("rst%0d_join_busy", i), join_busy_o[i], 0);
            chk($sformatf("rst%0d_yield_busy", i), yield_busy_o[i], 0);
        end
        reset = 1'b1;
        cyc(2 + $urandom_range(0, 3));

        // Run all three; hold run_req on the long ones, pulse start mid-run
        for (int i = 0; i < 3; i++) push_exp(i);
        run_req = 3'b111;
        cyc(1);                                  // k=0
        run_req = 3'b011;
        cyc(5);                                  // k=5
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("a%0d_run_busy_k5", i), run_busy_o[i], (5 < ref_cyc[i]) ? 1 : 0);
            chk($sformatf("a%0d_start_busy_k5", i), start_busy_o[i], (5 < ref_cyc[i]) ? 1 : 0);
            chk($sformatf("a%0d_join_busy_k5", i), join_busy_o[i], (5 < ref_cyc[i]) ? 1 : 0);
            chk($sformatf("a%0d_yield_busy_k5", i), yield_busy_o[i], 0);
        end
        cyc(4);                                  // k=9
        run_req = 3'b000;
        cyc(41);                                 // k=50
        start_req = 3'b001;
        cyc(1);                                  // k=51
        start_req = 3'b000;
        chk("a0_join_busy_k51", join_busy_o[0], (51 < ref_cyc[0]) ? 1 : 0);
        cyc(maxd + 10 - 51);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("a%0d_pending_after_bound", i), qsize(i), 0);
            chk($sformatf("a%0d_run_busy_end", i), run_busy_o[i], 0);
            chk($sformatf("a%0d_join_busy_end", i), join_busy_o[i], 0);
            chk($sformatf("a%0d_cnt_end", i), cnt_o[i], ref_cnt[i]);
            chk($sformatf("a%0d_last_end", i), last_o[i], ref_last[i]);
        end
        join_req = 1'b0;
        chk("a0_join_busy_released", join_busy_o[0], 0);

        // External field writes
        ff_we = 1'b1;
        ff_in = 1'b0;
        cyc(1);
        ff_we = 1'b0;
        for (int i = 0; i < 3; i++) chk($sformatf("b%0d_ff_write0", i), ff_o[i], 0);
        ff_we = 1'b1;
        ff_in = 1'b1;
        cyc(1);
        ff_we = 1'b0;
        ff_in = 1'b0;
        for (int i = 0; i < 3; i++) chk($sformatf("b%0d_ff_write1", i), ff_o[i], 1);

        // Second run on engine 0: INIT beats an external write of 1,
        // mid-run write sticks, DONE beats an external write of 0
        push_exp(0);
        run_req = 3'b001;
        cyc(1);                                  // k=0, INIT this cycle
        run_req = 3'b000;
        ff_we   = 1'b1;
        ff_in   = 1'b1;
        cyc(1);                                  // k=1
        ff_we   = 1'b0;
        ff_in   = 1'b0;
        cyc(1);                                  // k=2
        chk("c0_ff_cleared_by_init", ff_o[0], 0);
        chk("c1_ff_idle_untouched", ff_o[1], 1);
        cyc(18);                                 // k=20
        ff_we = 1'b1;
        ff_in = 1'b1;
        cyc(1);                                  // k=21
        ff_we = 1'b0;
        ff_in = 1'b0;
        chk("c0_ff_ext_write_midrun", ff_o[0], 1);
        cyc(19);                                 // k=40
        chk("c0_ff_held_midrun", ff_o[0], 1);
        chk("c0_run_busy_k40", run_busy_o[0], 1);
        cyc(ref_cyc[0] - 1 - 40);                // k=D-1, DONE this cycle
        ff_we = 1'b1;
        ff_in = 1'b0;
        cyc(1);                                  // k=D
        ff_we = 1'b0;
        chk("c1_ff_ext_write0", ff_o[1], 0);
        chk("c2_ff_ext_write0", ff_o[2], 0);
        cyc(10);
        chk("c0_pending_after_bound", qsize(0), 0);
        chk("c0_ff_after_done", ff_o[0], 1);
        chk("c0_cnt_not_accumulated", cnt_o[0], ref_cnt[0]);

        // Reset mid-run aborts engines 0 and 1
        push_exp(0);
        push_exp(1);
        run_req = 3'b011;
        cyc(1);                                  // k=0
        run_req = 3'b000;
        cyc(200);                                // k=200
        #2;
        reset = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        q2.delete();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d_async_ff", i), ff_o[i], 0);
            chk($sformatf("d%0d_async_cnt", i), cnt_o[i], 0);
            chk($sformatf("d%0d_async_last", i), last_o[i], 0);
            chk($sformatf("d%0d_async_busy", i), run_busy_o[i], 0);
        end
        cyc(3);
        reset = 1'b1;
        cyc(20);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d_idle_busy", i), run_busy_o[i], 0);
            chk($sformatf("d%0d_idle_ff", i), ff_o[i], 0);
            chk($sformatf("d%0d_idle_cnt", i), cnt_o[i], 0);
            chk($sformatf("d%0d_idle_last", i), last_o[i], 0);
        end

        for (int i = 0; i < 3; i++) chk($sformatf("final%0d_queue_empty", i), qsize(i), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
